// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM that sequences fetch/decode/execute/memory/writeback
// and drives every select and write enable of the IR/register-file/ALU datapath.
module multicycle_control_fsm #(
  parameter int ALU_CMD_W    = 3,
  parameter bit HALT_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 reg_we,
  output logic [1:0]           reg_dst_sel,
  output logic [1:0]           reg_data_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic [1:0]           pc_src_sel,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CMD_W-1:0] ALU_ADD = ALU_CMD_W'(0);
  localparam logic [ALU_CMD_W-1:0] ALU_SUB = ALU_CMD_W'(1);
  localparam logic [ALU_CMD_W-1:0] ALU_XOR = ALU_CMD_W'(2);
  localparam logic [ALU_CMD_W-1:0] ALU_SLT = ALU_CMD_W'(3);

  state_t state_q, state_d, decode_next;
  logic   decode_illegal;
  logic   mem_is_store;
  logic   illegal_q;

  // Instruction classification; only consulted while in DECODE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    decode_next    = FETCH;
    decode_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: decode_next = R_EXEC;
          FN_JR:                  decode_next = JR;
          default:                decode_illegal = 1'b1;
        endcase
      end
      OP_J:         decode_next = JUMP;
      OP_JAL:       decode_next = JAL;
      OP_BNE:       decode_next = BRANCH;
      OP_XORI:      decode_next = I_EXEC;
      OP_LW, OP_SW: decode_next = MEM_ADDR;
      default:      decode_illegal = 1'b1;
    endcase
    if (decode_illegal) decode_next = HALT_ILLEGAL ? HALT : FETCH;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = decode_next;
      MEM_ADDR: state_d = mem_is_store ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = MEM_WB;
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // Load/store direction is captured in DECODE so opcode changes later in the instruction are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together on the edge.
      state_q      <= FETCH;
      mem_is_store <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        mem_is_store <= (opcode == OP_SW);
        if (decode_illegal) illegal_q <= 1'b1;
      end
    end
  end

  // Moore outputs; reset gates everything to zero so nothing fires while it is held.
  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    reg_dst_sel  = 2'd0;
    reg_data_sel = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_cmd      = ALU_ADD;
    pc_src_sel   = 2'd0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alu_src_b = 2'd2;
        end
        DECODE: alu_src_b = 2'd3;
        MEM_ADDR: alu_src_a = 1'b1;
        MEM_RD: mem_addr_sel = 1'b1;
        MEM_WB: begin
          reg_we       = 1'b1;
          reg_dst_sel  = 2'd1;
          reg_data_sel = 2'd1;
        end
        MEM_WR: begin
          mem_addr_sel = 1'b1;
          mem_we       = 1'b1;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd1;
          case (funct)
            FN_SUB:  alu_cmd = ALU_SUB;
            FN_SLT:  alu_cmd = ALU_SLT;
            default: alu_cmd = ALU_ADD;
          endcase
        end
        R_WB: reg_we = 1'b1;
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_cmd   = ALU_XOR;
        end
        I_WB: begin
          reg_we      = 1'b1;
          reg_dst_sel = 2'd1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd1;
          alu_cmd    = ALU_SUB;
          pc_src_sel = 2'd1;
          pc_we      = ~zero;
        end
        JUMP: begin
          pc_src_sel = 2'd2;
          pc_we      = 1'b1;
        end
        JAL: begin
          pc_src_sel   = 2'd2;
          pc_we        = 1'b1;
          reg_we       = 1'b1;
          reg_dst_sel  = 2'd2;
          reg_data_sel = 2'd2;
        end
        JR: begin
          pc_src_sel = 2'd3;
          pc_we      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm: walks each instruction class state by state
// against hand-written control vectors, plus reset abort and illegal-opcode handling.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       ir_we, pc_we, mem_we, mem_addr_sel, reg_we, alu_src_a, illegal;
  logic [1:0] reg_dst_sel, reg_data_sel, alu_src_b, pc_src_sel;
  logic [2:0] alu_cmd;
  logic [3:0] state;

  logic       ir_we_n, pc_we_n, mem_we_n, mem_addr_sel_n, reg_we_n, alu_src_a_n, illegal_n;
  logic [1:0] reg_dst_sel_n, reg_data_sel_n, alu_src_b_n, pc_src_sel_n;
  logic [2:0] alu_cmd_n;
  logic [3:0] state_n;

  int assertions_evaluated = 0;
  int failures = 0;

  multicycle_control_fsm #(.ALU_CMD_W(3), .HALT_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .reg_we(reg_we), .reg_dst_sel(reg_dst_sel), .reg_data_sel(reg_data_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_cmd(alu_cmd),
    .pc_src_sel(pc_src_sel), .illegal(illegal), .state(state)
  );

  multicycle_control_fsm #(.ALU_CMD_W(3), .HALT_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(ir_we_n), .pc_we(pc_we_n), .mem_we(mem_we_n), .mem_addr_sel(mem_addr_sel_n),
    .reg_we(reg_we_n), .reg_dst_sel(reg_dst_sel_n), .reg_data_sel(reg_data_sel_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_cmd(alu_cmd_n),
    .pc_src_sel(pc_src_sel_n), .illegal(illegal_n), .state(state_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] ctl_act;
  assign ctl_act = {ir_we, pc_we, mem_we, mem_addr_sel, reg_we, reg_dst_sel, reg_data_sel,
                    alu_src_a, alu_src_b, alu_cmd, pc_src_sel};

  function automatic logic [16:0] ctl(input bit ir, input bit pc, input bit mw, input bit mas,
                                      input bit rw, input logic [1:0] dst, input logic [1:0] data,
                                      input bit a, input logic [1:0] b, input logic [2:0] cmd,
                                      input logic [1:0] psrc);
    return {ir, pc, mw, mas, rw, dst, data, a, b, cmd, psrc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions_evaluated++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input int st, input logic [16:0] c);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctl"}, 32'(ctl_act), 32'(c));
  endtask

  task automatic step(input string tag, input int st, input logic [16:0] c);
    @(posedge clk);
    #2;
    expect_st(tag, st, c);
  endtask

  logic [16:0] c_fetch, c_decode, c_zero;
  logic [5:0]  r_funct [3];
  logic [2:0]  r_cmd   [3];

  initial begin
    c_fetch  = ctl(1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd2, 3'd0, 2'd0);
    c_decode = ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 3'd0, 2'd0);
    c_zero   = 17'd0;
    r_funct[0] = 6'h20; r_cmd[0] = 3'd0;
    r_funct[1] = 6'h22; r_cmd[1] = 3'd1;
    r_funct[2] = 6'h2A; r_cmd[2] = 3'd3;

    reset  = 1'b1;
    opcode = 6'h2B;
    funct  = 6'h00;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    expect_st("rst", 0, c_zero);
    check("rst.illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    expect_st("sw.fetch", 0, c_fetch);

    // SW interrupted by reset in MEM_WR
    step("sw.decode", 1, c_decode);
    step("sw.addr", 2, ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'd0, 2'd0));
    step("sw.wr", 5, ctl(0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0));
    reset = 1'b1;
    #1;
    expect_st("midrst", 0, c_zero);
    check("midrst.mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #2;
    expect_st("midrst.held", 0, c_zero);
    reset  = 1'b0;
    opcode = 6'h23;
    #1;
    expect_st("postrst.fetch", 0, c_fetch);

    // LW; opcode changed after DECODE must be ignored
    step("lw.decode", 1, c_decode);
    step("lw.addr", 2, ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'd0, 2'd0));
    opcode = 6'h2B;
    step("lw.rd", 3, ctl(0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0));
    step("lw.wb", 4, ctl(0, 0, 0, 0, 1, 2'd1, 2'd1, 0, 2'd0, 3'd0, 2'd0));
    step("lw.next", 0, c_fetch);

    // R-type ALU ops
    opcode = 6'h00;
    for (int i = 0; i < 3; i++) begin
      funct = r_funct[i];
      step($sformatf("r%0d.decode", i), 1, c_decode);
      step($sformatf("r%0d.exec", i), 6, ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, r_cmd[i], 2'd0));
      step($sformatf("r%0d.wb", i), 7, ctl(0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0));
      step($sformatf("r%0d.next", i), 0, c_fetch);
    end

    // XORI
    opcode = 6'h0E;
    step("xori.decode", 1, c_decode);
    step("xori.exec", 8, ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'd2, 2'd0));
    step("xori.wb", 9, ctl(0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 3'd0, 2'd0));
    step("xori.next", 0, c_fetch);

    // BNE taken/not taken
    opcode = 6'h05;
    zero   = 1'b1;
    step("bne_z1.decode", 1, c_decode);
    step("bne_z1.branch", 10, ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd1, 2'd1));
    step("bne_z1.next", 0, c_fetch);
    zero = 1'b0;
    step("bne_z0.decode", 1, c_decode);
    step("bne_z0.branch", 10, ctl(0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd1, 2'd1));
    step("bne_z0.next", 0, c_fetch);

    // J, JAL, JR
    opcode = 6'h02;
    step("j.decode", 1, c_decode);
    step("j.jump", 11, ctl(0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd2));
    step("j.next", 0, c_fetch);
    opcode = 6'h03;
    step("jal.decode", 1, c_decode);
    step("jal.jal", 12, ctl(0, 1, 0, 0, 1, 2'd2, 2'd2, 0, 2'd0, 3'd0, 2'd2));
    step("jal.next", 0, c_fetch);
    opcode = 6'h00;
    funct  = 6'h08;
    step("jr.decode", 1, c_decode);
    step("jr.jr", 13, ctl(0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd3));
    step("jr.next", 0, c_fetch);

    // Illegal opcode: HALT with HALT_ILLEGAL=1, back to FETCH with HALT_ILLEGAL=0
    opcode = 6'h3F;
    step("ill.decode", 1, c_decode);
    check("ill.pre_illegal", 32'(illegal), 32'd0);
    step("ill.halt", 15, c_zero);
    check("ill.illegal", 32'(illegal), 32'd1);
    check("ill_nop.state", 32'(state_n), 32'd0);
    check("ill_nop.illegal", 32'(illegal_n), 32'd1);
    opcode = 6'h23;
    for (int i = 0; i < 20; i++) step($sformatf("halt%0d", i), 15, c_zero);
    check("halt.illegal_sticky", 32'(illegal), 32'd1);

    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    expect_st("halt_rst", 0, c_fetch);
    check("halt_rst.illegal", 32'(illegal), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
